// File: rtl/id_ex_pipe_reg.sv
// id_ex_pipe_reg: ID/EX pipeline register for the 5-stage RV32I core.
//
// Captures decode-stage control, data and register indices into the E stage.
// It supports hold (stall_e), bubble insertion (flush_e) and a valid bit.
// It also resolves conditional branches and JAL/JALR in the E stage, and
// keeps saturating bubble/stall counters for performance debug.
//
// Ports:
//   clk, rst                 rising-edge clock, synchronous active-high reset
//   stall_e, flush_e         hold / bubble controls (flush wins over stall)
//   valid_d, *_d             decode-stage slot contents
//   fwd_a_e, fwd_b_e         forwarded E-stage operands (compare and JALR base)
//   *_e                      registered copies of every *_d input
//   pc_src_e, pc_target_e    redirect request and target
//   flush_cnt, stall_cnt     saturating performance counters
module id_ex_pipe_reg #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned ALUC_W = 5,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_e,
  input  logic              flush_e,
  input  logic              valid_d,
  input  logic              reg_write_d,
  input  logic              mem_write_d,
  input  logic              jump_d,
  input  logic              branch_d,
  input  logic              alu_src_d,
  input  logic              jalr_d,
  input  logic [1:0]        result_src_d,
  input  logic [ALUC_W-1:0] alu_ctrl_d,
  input  logic [2:0]        funct3_d,
  input  logic [XLEN-1:0]   pc_d,
  input  logic [XLEN-1:0]   pc_plus4_d,
  input  logic [XLEN-1:0]   imm_ext_d,
  input  logic [XLEN-1:0]   rd1_d,
  input  logic [XLEN-1:0]   rd2_d,
  input  logic [REG_AW-1:0] rd_d,
  input  logic [REG_AW-1:0] rs1_d,
  input  logic [REG_AW-1:0] rs2_d,
  input  logic [XLEN-1:0]   fwd_a_e,
  input  logic [XLEN-1:0]   fwd_b_e,
  output logic              valid_e,
  output logic              reg_write_e,
  output logic              mem_write_e,
  output logic              jump_e,
  output logic              branch_e,
  output logic              alu_src_e,
  output logic              jalr_e,
  output logic [1:0]        result_src_e,
  output logic [ALUC_W-1:0] alu_ctrl_e,
  output logic [2:0]        funct3_e,
  output logic [XLEN-1:0]   pc_e,
  output logic [XLEN-1:0]   pc_plus4_e,
  output logic [XLEN-1:0]   imm_ext_e,
  output logic [XLEN-1:0]   rd1_e,
  output logic [XLEN-1:0]   rd2_e,
  output logic [REG_AW-1:0] rd_e,
  output logic [REG_AW-1:0] rs1_e,
  output logic [REG_AW-1:0] rs2_e,
  output logic              pc_src_e,
  output logic [XLEN-1:0]   pc_target_e,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic            cond;
  logic [XLEN-1:0] jalr_sum;

  // Reset and flush both load an all-zero bubble; stall simply skips the load.
  always_ff @(posedge clk) begin
    if (rst || flush_e) begin
      valid_e      <= 1'b0;
      reg_write_e  <= 1'b0;
      mem_write_e  <= 1'b0;
      jump_e       <= 1'b0;
      branch_e     <= 1'b0;
      alu_src_e    <= 1'b0;
      jalr_e       <= 1'b0;
      result_src_e <= '0;
      alu_ctrl_e   <= '0;
      funct3_e     <= '0;
      pc_e         <= '0;
      pc_plus4_e   <= '0;
      imm_ext_e    <= '0;
      rd1_e        <= '0;
      rd2_e        <= '0;
      rd_e         <= '0;
      rs1_e        <= '0;
      rs2_e        <= '0;
    end else if (!stall_e) begin
      valid_e      <= valid_d;
      reg_write_e  <= reg_write_d;
      mem_write_e  <= mem_write_d;
      jump_e       <= jump_d;
      branch_e     <= branch_d;
      alu_src_e    <= alu_src_d;
      jalr_e       <= jalr_d;
      result_src_e <= result_src_d;
      alu_ctrl_e   <= alu_ctrl_d;
      funct3_e     <= funct3_d;
      pc_e         <= pc_d;
      pc_plus4_e   <= pc_plus4_d;
      imm_ext_e    <= imm_ext_d;
      rd1_e        <= rd1_d;
      rd2_e        <= rd2_d;
      rd_e         <= rd_d;
      rs1_e        <= rs1_d;
      rs2_e        <= rs2_d;
    end
  end

  // A flush cycle counts only as a bubble, never as a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (flush_e && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
      if (stall_e && !flush_e && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    cond     = 1'b0;
    jalr_sum = fwd_a_e + imm_ext_e;
    case (funct3_e)
      3'b000:  cond = (fwd_a_e == fwd_b_e);
      3'b001:  cond = (fwd_a_e != fwd_b_e);
      3'b100:  cond = ($signed(fwd_a_e) <  $signed(fwd_b_e));
      3'b101:  cond = ($signed(fwd_a_e) >= $signed(fwd_b_e));
      3'b110:  cond = (fwd_a_e <  fwd_b_e);
      3'b111:  cond = (fwd_a_e >= fwd_b_e);
      default: cond = 1'b0;
    endcase
    // valid_e gates everything so a bubble can never redirect.
    pc_src_e = valid_e & ((branch_e & cond) | jump_e);
    if (jalr_e)
      pc_target_e = {jalr_sum[XLEN-1:1], 1'b0};
    else
      pc_target_e = pc_e + imm_ext_e;
  end

endmodule
